// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequences the ALU and its result mux for one op per start/done handshake; optional SHIFT_SAT_EN saturates shift amounts >= W
`timescale 1ns/1ps
module alu_op_sequencer #(
    parameter int W   = 16,
    parameter int SHW = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    output logic         Ready,
    input  logic [3:0]   Op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [2:0]   Sel,
    output logic         BNegate,
    output logic [W-1:0] OpA,
    output logic [W-1:0] OpB,
    input  logic [W-1:0] AluResult,
    output logic [W-1:0] Result,
    output logic         Done,
    output logic         Err
);
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
    state_t         state_q, state_d;
    logic [3:0]     op_q, op_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [2:0]     sel_q, sel_d;
    logic           bneg_q, bneg_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   result_q, result_d;
    logic           err_q, err_d;
    logic [SHW-1:0] amt;
    logic           sat;
    logic           unused_b;
    logic           is_shift;
    logic           legal;
`ifdef SHIFT_SAT_EN
    assign amt      = B[SHW-1:0];
    assign sat      = B[SHW];
    assign unused_b = ^B[W-1:SHW+1];
`else
    assign amt      = B[SHW-1:0];
    assign sat      = 1'b0;
    assign unused_b = ^B[W-1:SHW];
`endif
    assign is_shift = Op[3:1] == 3'b011;
    assign legal    = !Op[3] || Op == 4'b1100;
    assign Ready    = state_q == IDLE;
    assign Done     = state_q == DONE;
    assign Sel      = sel_q;
    assign BNegate  = bneg_q;
    assign OpA      = opa_q;
    assign OpB      = opb_q;
    assign Result   = result_q;
    assign Err      = err_q;
    // next-state and datapath: decode on accept, one EXEC pass or n SHIFT passes, then DONE
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        bneg_d   = bneg_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (Start) begin
                op_d  = Op;
                err_d = 1'b0;
                if (!legal) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = DONE;
                end else if (is_shift && sat) begin
                    result_d = Op[0] ? {W{A[W-1]}} : '0;
                    state_d  = DONE;
                end else if (is_shift && amt == '0) begin
                    result_d = A;
                    state_d  = DONE;
                end else if (is_shift) begin
                    cnt_d   = amt;
                    opa_d   = A;
                    opb_d   = W'(1);
                    sel_d   = Op[2:0];
                    bneg_d  = 1'b0;
                    state_d = SHIFT;
                end else begin
                    opa_d   = A;
                    opb_d   = B;
                    sel_d   = Op[2:0];
                    bneg_d  = Op[3];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = AluResult;
                state_d  = DONE;
            end
            SHIFT: begin
                opa_d = AluResult;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d = AluResult;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            bneg_q   <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            bneg_q   <= bneg_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench for alu_op_sequencer with a behavioural ALU
`timescale 1ns/1ps
module tb_alu_op_sequencer;
    localparam int W = 16;
    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic         Ready;
    logic [3:0]   Op = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   Sel;
    logic         BNegate;
    logic [W-1:0] OpA;
    logic [W-1:0] OpB;
    logic [W-1:0] AluResult;
    logic [W-1:0] Result;
    logic         Done;
    logic         Err;
    int           n_checks = 0;
    int           n_fail = 0;

    alu_op_sequencer #(.W(W), .SHW(4)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Ready(Ready), .Op(Op), .A(A), .B(B),
        .Sel(Sel), .BNegate(BNegate), .OpA(OpA), .OpB(OpB), .AluResult(AluResult),
        .Result(Result), .Done(Done), .Err(Err)
    );

    always #5 Clock = ~Clock;

    // behavioural ALU plus result mux driven by the sequencer
    always_comb begin
        case (Sel)
            3'b000:  AluResult = OpA & OpB;
            3'b001:  AluResult = ($signed(OpA) < $signed(OpB)) ? W'(1) : W'(0);
            3'b010:  AluResult = OpA | OpB;
            3'b011:  AluResult = OpA ^ OpB;
            3'b110:  AluResult = OpA << OpB[3:0];
            3'b111:  AluResult = W'($signed(OpA) >>> OpB[3:0]);
            default: AluResult = BNegate ? OpA - OpB : OpA + OpB;
        endcase
    end

    task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clock);
        Op = op; A = a; B = b; Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
    endtask

    task automatic wait_done(input int maxk, output int k);
        k = -1;
        for (int i = 1; i <= maxk; i++) begin
            @(negedge Clock);
            if (Done === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        n_checks++; if (Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", Ready); end
        n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
        n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", Err); end
        n_checks++; if (Result !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0000", Result); end
        n_checks++; if ({Sel, BNegate, OpA, OpB} !== 36'h0) begin n_fail++; $display("FAIL reset_alu_ctl: got %b %b %h %h want zeros", Sel, BNegate, OpA, OpB); end
        Reset = 1'b0;
    endtask

    task automatic test_add;
        start_op(4'b0100, 16'h1234, 16'h0001);
        @(negedge Clock);
        n_checks++; if ({Sel, BNegate} !== 4'b1000) begin n_fail++; $display("FAIL add_ctl: got sel=%b bneg=%b want 100/0", Sel, BNegate); end
        n_checks++; if (OpA !== 16'h1234 || OpB !== 16'h0001) begin n_fail++; $display("FAIL add_ops: got %h %h want 1234 0001", OpA, OpB); end
        n_checks++; if (Done !== 1'b0 || Ready !== 1'b0) begin n_fail++; $display("FAIL add_exec_flags: got done=%b ready=%b want 0 0", Done, Ready); end
        @(negedge Clock);
        n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL add_done_t2: got %b want 1", Done); end
        n_checks++; if (Result !== 16'h1235) begin n_fail++; $display("FAIL add_result: got %h want 1235", Result); end
        n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL add_err: got %b want 0", Err); end
        @(negedge Clock);
        n_checks++; if (Done !== 1'b0 || Ready !== 1'b1) begin n_fail++; $display("FAIL add_after: got done=%b ready=%b want 0 1", Done, Ready); end
    endtask

    task automatic test_sub;
        start_op(4'b1100, 16'h0005, 16'h0007);
        @(negedge Clock);
        n_checks++; if ({Sel, BNegate} !== 4'b1001) begin n_fail++; $display("FAIL sub_ctl: got sel=%b bneg=%b want 100/1", Sel, BNegate); end
        @(negedge Clock);
        n_checks++; if (Done !== 1'b1 || Result !== 16'hFFFE) begin n_fail++; $display("FAIL sub_result: got done=%b res=%h want 1 fffe", Done, Result); end
    endtask

    task automatic test_sll;
        logic [W-1:0] exp_opa [4];
        exp_opa[0] = 16'h0001; exp_opa[1] = 16'h0002; exp_opa[2] = 16'h0004; exp_opa[3] = 16'h0008;
        start_op(4'b0110, 16'h0001, 16'h0004);
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clock);
            if (k == 2) begin Op = 4'b0100; A = 16'h00FF; B = 16'h00FF; Start = 1'b1; end
            if (k == 3) Start = 1'b0;
            n_checks++; if (OpA !== exp_opa[k-1] || OpB !== 16'h0001) begin n_fail++; $display("FAIL sll_ops_k%0d: got %h %h want %h 0001", k, OpA, OpB, exp_opa[k-1]); end
            n_checks++; if (Sel !== 3'b110 || BNegate !== 1'b0 || Done !== 1'b0) begin n_fail++; $display("FAIL sll_ctl_k%0d: got sel=%b bneg=%b done=%b want 110 0 0", k, Sel, BNegate, Done); end
        end
        @(negedge Clock);
        n_checks++; if (Done !== 1'b1 || Result !== 16'h0010) begin n_fail++; $display("FAIL sll_done_t5: got done=%b res=%h want 1 0010", Done, Result); end
        @(negedge Clock);
        n_checks++; if (Ready !== 1'b1 || Done !== 1'b0) begin n_fail++; $display("FAIL sll_no_queue: got ready=%b done=%b want 1 0", Ready, Done); end
    endtask

    task automatic test_sra_zero;
        start_op(4'b0111, 16'h8000, 16'h0000);
        @(negedge Clock);
        n_checks++; if (Done !== 1'b1 || Result !== 16'h8000) begin n_fail++; $display("FAIL sra0_done_t1: got done=%b res=%h want 1 8000", Done, Result); end
        n_checks++; if (OpA !== 16'h0010 || Sel !== 3'b110) begin n_fail++; $display("FAIL sra0_alu_idle: got opa=%h sel=%b want 0010 110", OpA, Sel); end
    endtask

    task automatic test_sra_big;
        int k;
        logic [W-1:0] exp_res;
        int exp_k;
`ifdef SHIFT_SAT_EN
        exp_k = 1; exp_res = 16'hFFFF;
`else
        exp_k = 5; exp_res = 16'hF800;
`endif
        start_op(4'b0111, 16'h8000, 16'h0014);
        wait_done(20, k);
        n_checks++; if (k !== exp_k) begin n_fail++; $display("FAIL sra_big_latency: got %0d want %0d", k, exp_k); end
        n_checks++; if (Result !== exp_res) begin n_fail++; $display("FAIL sra_big_result: got %h want %h", Result, exp_res); end
        @(negedge Clock);
    endtask

    task automatic test_illegal;
        start_op(4'b1010, 16'h1234, 16'h5678);
        @(negedge Clock);
        n_checks++; if (Done !== 1'b1 || Err !== 1'b1 || Result !== 16'h0) begin n_fail++; $display("FAIL illegal: got done=%b err=%b res=%h want 1 1 0000", Done, Err, Result); end
        @(negedge Clock);
        n_checks++; if (Err !== 1'b1 || Done !== 1'b0) begin n_fail++; $display("FAIL illegal_err_hold: got err=%b done=%b want 1 0", Err, Done); end
        start_op(4'b0100, 16'h0002, 16'h0003);
        @(negedge Clock);
        n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_clear: got %b want 0", Err); end
        @(negedge Clock);
        n_checks++; if (Done !== 1'b1 || Result !== 16'h0005) begin n_fail++; $display("FAIL add_after_illegal: got done=%b res=%h want 1 0005", Done, Result); end
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        start_op(4'b0110, 16'h0001, 16'h000A);
        repeat (3) @(negedge Clock);
        n_checks++; if (OpA !== 16'h0004) begin n_fail++; $display("FAIL rstmid_shift3_opa: got %h want 0004", OpA); end
        Reset = 1'b1;
        @(negedge Clock);
        n_checks++; if (Ready !== 1'b1 || Result !== 16'h0 || Done !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got ready=%b res=%h done=%b want 1 0000 0", Ready, Result, Done); end
        n_checks++; if (OpA !== 16'h0 || Sel !== 3'b000 || OpB !== 16'h0) begin n_fail++; $display("FAIL rstmid_alu_ctl: got opa=%h sel=%b opb=%h want 0", OpA, Sel, OpB); end
        Reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            if (Done === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_sll;
        test_sra_zero;
        test_sra_big;
        test_illegal;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
